// File: rtl/row_store_controller.sv
// Row store controller: once per scan line, writes the row calculator's finished
// row into 16-bit board RAM word by word. It then reads the next row back and
// presents it as one wide register, together with a one-cycle `reading` strobe.
module row_store_controller #(
    parameter int ROW_BITS  = 640,
    parameter int WORD_BITS = 16,
    parameter int ROWS      = 480,
    parameter int ADDR_BITS = 15,
    parameter int IDX_BITS  = 9
) (
    input  logic                 clkDiv,
    input  logic                 rst,
    input  logic                 lineStart,
    input  logic                 writeBack,
    input  logic [IDX_BITS-1:0]  writeRowIndex,
    input  logic [IDX_BITS-1:0]  readRowIndex,
    input  logic [ROW_BITS-1:0]  writeRow,
    output logic [ROW_BITS-1:0]  readRow,
    output logic                 reading,
    output logic                 busy,
    output logic                 overrun,
    output logic [ADDR_BITS-1:0] memAddr,
    output logic                 memWrite,
    output logic                 memRead,
    output logic [WORD_BITS-1:0] memWriteData,
    input  logic [WORD_BITS-1:0] memReadData
);

    localparam int WORDS    = ROW_BITS / WORD_BITS;
    localparam int CNT_BITS = $clog2(WORDS);

    localparam logic [CNT_BITS-1:0]  LAST_WORD = CNT_BITS'(WORDS - 1);
    localparam logic [ADDR_BITS-1:0] WORDS_A   = ADDR_BITS'(WORDS);
    localparam logic [IDX_BITS-1:0]  ROWS_I    = IDX_BITS'(ROWS);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        FILL,
        DONE
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [CNT_BITS-1:0]   word;
    logic                  write_back;
    logic [IDX_BITS-1:0]   write_idx;
    logic [IDX_BITS-1:0]   read_idx;
    logic [ROW_BITS-1:0]   snapshot;
    logic [ROW_BITS-1:0]   shadow;
    logic                  accept;
    logic                  last_word;
    logic                  write_ok;
    logic                  read_ok;
    logic                  capture;
    logic [WORD_BITS-1:0]  capture_word;

    assign accept    = (state == IDLE) && lineStart;
    assign last_word = (word == LAST_WORD);
    // Rows outside the board still take their full slot, but never touch the RAM.
    assign write_ok  = (write_idx < ROWS_I);
    assign read_ok   = (read_idx < ROWS_I);

    // Read data lags its address by one cycle: word k lands during READ word k+1,
    // and the last word lands in FILL. A dead row reads back as zeros.
    assign capture      = ((state == READ) && (word != '0)) || (state == FILL);
    assign capture_word = read_ok ? memReadData : '0;

    // State register.
    always_ff @(posedge clkDiv or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and RAM-side outputs, decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        next_state   = state;
        busy         = 1'b1;
        memWrite     = 1'b0;
        memRead      = 1'b0;
        memAddr      = '0;
        memWriteData = '0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (lineStart) begin
                    next_state = writeBack ? WRITE : READ;
                end
            end
            WRITE: begin
                memWrite     = write_ok;
                memAddr      = ADDR_BITS'(write_idx) * WORDS_A + ADDR_BITS'(word);
                memWriteData = snapshot[WORD_BITS-1:0];
                if (last_word) begin
                    next_state = READ;
                end
            end
            READ: begin
                memRead = read_ok;
                memAddr = ADDR_BITS'(read_idx) * WORDS_A + ADDR_BITS'(word);
                if (last_word) begin
                    next_state = FILL;
                end
            end
            FILL:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control registers: word counter, latched request, result row, strobe, sticky overrun.
    always_ff @(posedge clkDiv or posedge rst) begin
        if (rst) begin
            word       <= '0;
            write_back <= 1'b0;
            write_idx  <= '0;
            read_idx   <= '0;
            readRow    <= '0;
            reading    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            if ((state == WRITE) || (state == READ)) begin
                word <= last_word ? '0 : word + 1'b1;
            end else begin
                word <= '0;
            end

            if (accept) begin
                write_back <= writeBack;
                write_idx  <= writeRowIndex;
                read_idx   <= readRowIndex;
            end

            // readRow and the strobe change on the same edge, so the row is already valid while reading is high.
            reading <= (state == FILL);
            if (state == FILL) begin
                readRow <= {capture_word, shadow[ROW_BITS-1:WORD_BITS]};
            end

            if (lineStart && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    // Row data paths: outgoing snapshot shifts down one word per write, incoming words shift in from the top.
    always_ff @(posedge clkDiv) begin
        // NOTE: these wide data registers have no reset; every bit is overwritten before it is ever observed.
        if (accept) begin
            snapshot <= writeRow;
        end else if (state == WRITE) begin
            snapshot <= snapshot >> WORD_BITS;
        end

        if (capture) begin
            shadow <= {capture_word, shadow[ROW_BITS-1:WORD_BITS]};
        end
    end

endmodule

// File: tb/tb_row_store_controller.sv
// Self-checking bench for row_store_controller: a directed table, a reset-abort
// sequence and random transactions, all scored against a transaction-level model.
module tb_row_store_controller;

    logic         clkDiv = 1'b0;
    logic         rst;
    logic         lineStart;
    logic         writeBack;
    logic [8:0]   writeRowIndex;
    logic [8:0]   readRowIndex;
    logic [639:0] writeRow;
    logic [639:0] readRow;
    logic         reading;
    logic         busy;
    logic         overrun;
    logic [14:0]  memAddr;
    logic         memWrite;
    logic         memRead;
    logic [15:0]  memWriteData;
    logic [15:0]  memReadData;

    row_store_controller dut (
        .clkDiv        (clkDiv),
        .rst           (rst),
        .lineStart     (lineStart),
        .writeBack     (writeBack),
        .writeRowIndex (writeRowIndex),
        .readRowIndex  (readRowIndex),
        .writeRow      (writeRow),
        .readRow       (readRow),
        .reading       (reading),
        .busy          (busy),
        .overrun       (overrun),
        .memAddr       (memAddr),
        .memWrite      (memWrite),
        .memRead       (memRead),
        .memWriteData  (memWriteData),
        .memReadData   (memReadData)
    );

    always #5 clkDiv = ~clkDiv;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_row(input string name, input logic [639:0] act, input logic [639:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- board RAM (synchronous, one-cycle read latency) ----------------
    function automatic logic [15:0] init_val(input int a);
        int r;
        int k;
        r = a / 40;
        k = a % 40;
        if (r == 7) return 16'(16'h0700 + k);
        return 16'(a * 7) ^ 16'h3c3c;
    endfunction

    logic [15:0] ram     [0:32767];
    bit          written [0:32767];
    logic [15:0] rd_q;

    always @(posedge clkDiv) begin
        if (memWrite) begin
            ram[memAddr]     <= memWriteData;
            written[memAddr] <= 1'b1;
        end
        if (memRead) rd_q <= written[memAddr] ? ram[memAddr] : init_val(int'(memAddr));
        else         rd_q <= 16'($urandom);
    end
    assign memReadData = rd_q;

    // ---------------- cycle counter and output monitor ----------------
    typedef struct {
        int          cyc;
        logic [14:0] addr;
        logic [15:0] data;
    } ev_t;

    typedef struct {
        int           cyc;
        logic [639:0] row;
    } strobe_t;

    int      cyc = 0;
    ev_t     wq[$];
    ev_t     rq[$];
    strobe_t sq[$];
    int      bq[$];
    int      both_hi  = 0;
    int      idle_bad = 0;
    ev_t     mon_ev;
    strobe_t mon_st;

    always @(posedge clkDiv) cyc <= cyc + 1;

    always @(negedge clkDiv) begin
        if (memWrite) begin
            mon_ev.cyc = cyc; mon_ev.addr = memAddr; mon_ev.data = memWriteData;
            wq.push_back(mon_ev);
        end
        if (memRead) begin
            mon_ev.cyc = cyc; mon_ev.addr = memAddr; mon_ev.data = 16'h0;
            rq.push_back(mon_ev);
        end
        if (reading) begin
            mon_st.cyc = cyc; mon_st.row = readRow;
            sq.push_back(mon_st);
        end
        if (busy) bq.push_back(cyc);
        if (memWrite && memRead) both_hi++;
        if (!busy && (memAddr != 0 || memWriteData != 0 || memWrite || memRead)) idle_bad++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- transaction-level reference model ----------------
    logic [15:0] model_ram [0:32767];

    typedef struct {
        bit wb;
        int widx;
        int ridx;
        int pattern;     // 0: word k = A500+k, 1: random
        int extra_at;    // cycle offset of a stray lineStart, 0 = none
        bit scramble;    // change writeRow every cycle after accept
        int exp_writes;
        int exp_waddr0;
        int exp_reads;
        int exp_raddr0;
        int exp_done;
    } vec_t;

    function automatic vec_t make_vec(input bit wb, input int widx, input int ridx,
                                      input int pat, input int extra, input bit scr);
        vec_t v;
        v.wb = wb; v.widx = widx; v.ridx = ridx;
        v.pattern = pat; v.extra_at = extra; v.scramble = scr;
        v.exp_writes = (wb && widx < 480) ? 40 : 0;
        v.exp_waddr0 = widx * 40;
        v.exp_reads  = (ridx < 480) ? 40 : 0;
        v.exp_raddr0 = ridx * 40;
        v.exp_done   = wb ? 82 : 42;
        return v;
    endfunction

    function automatic logic [639:0] rand_row();
        logic [639:0] r;
        for (int i = 0; i < 20; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [639:0] model_row(input int ridx);
        logic [639:0] r;
        r = '0;
        if (ridx < 480)
            for (int k = 0; k < 40; k++) r[16*k +: 16] = model_ram[ridx*40 + k];
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        logic [639:0] row;
        logic [639:0] exp_row;
        int n, w0, r0, s0, b0, mism, rd_start;

        if (v.pattern == 0) for (int k = 0; k < 40; k++) row[16*k +: 16] = 16'(16'hA500 + k);
        else                row = rand_row();

        @(negedge clkDiv); #1;
        w0 = wq.size(); r0 = rq.size(); s0 = sq.size(); b0 = bq.size();
        writeBack     = v.wb;
        writeRowIndex = 9'(v.widx);
        readRowIndex  = 9'(v.ridx);
        writeRow      = row;
        lineStart     = 1'b1;
        n             = cyc;

        for (int t = 1; t <= v.exp_done + 2; t++) begin
            @(negedge clkDiv); #1;
            lineStart = (t == v.extra_at);
            if (t == v.extra_at) begin
                writeBack     = ~v.wb;
                writeRowIndex = 9'($urandom);
                readRowIndex  = 9'($urandom);
                writeRow      = rand_row();
            end
            if (v.scramble) writeRow = rand_row();
        end

        if (v.wb && v.widx < 480)
            for (int k = 0; k < 40; k++) model_ram[v.widx*40 + k] = row[16*k +: 16];
        exp_row = model_row(v.ridx);

        check({tag, ".wr_count"}, wq.size() - w0, v.exp_writes);
        mism = 0;
        for (int i = 0; i < wq.size() - w0 && i < 40; i++) begin
            if (wq[w0+i].cyc != n + 1 + i || int'(wq[w0+i].addr) != v.exp_waddr0 + i ||
                wq[w0+i].data !== row[16*i +: 16]) mism++;
        end
        check({tag, ".wr_events"}, mism, 0);

        rd_start = n + 1 + (v.wb ? 40 : 0);
        check({tag, ".rd_count"}, rq.size() - r0, v.exp_reads);
        mism = 0;
        for (int i = 0; i < rq.size() - r0 && i < 40; i++) begin
            if (rq[r0+i].cyc != rd_start + i || int'(rq[r0+i].addr) != v.exp_raddr0 + i) mism++;
        end
        check({tag, ".rd_events"}, mism, 0);

        check({tag, ".strobe_count"}, sq.size() - s0, 1);
        if (sq.size() > s0) begin
            check({tag, ".strobe_cycle"}, sq[s0].cyc - n, v.exp_done);
            check_row({tag, ".row_at_strobe"}, sq[s0].row, exp_row);
        end
        check_row({tag, ".row_after"}, readRow, exp_row);

        check({tag, ".busy_cycles"}, bq.size() - b0, v.exp_done);
        if (bq.size() > b0) check({tag, ".busy_first"}, bq[b0] - n, 1);
    endtask

    // Abort a write-back of row 12 with reset during cycle N+20.
    task automatic reset_abort_test();
        logic [639:0] row;
        int w0, s0;
        row = rand_row();
        @(negedge clkDiv); #1;
        writeBack = 1'b1; writeRowIndex = 9'd12; readRowIndex = 9'd12;
        writeRow = row; lineStart = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clkDiv); #1;
            lineStart = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("rst_abort.memWrite", int'(memWrite), 0);
        check("rst_abort.busy", int'(busy), 0);
        check("rst_abort.reading", int'(reading), 0);
        check("rst_abort.overrun", int'(overrun), 0);
        check_row("rst_abort.readRow", readRow, '0);
        // Words written at N+1..N+19 reached RAM; word 19 was cut off by reset.
        for (int k = 0; k < 19; k++) model_ram[480 + k] = row[16*k +: 16];
        w0 = wq.size(); s0 = sq.size();
        repeat (3) @(negedge clkDiv);
        #1 rst = 1'b0;
        repeat (45) @(negedge clkDiv);
        #1;
        check("rst_abort.no_writes_after", wq.size() - w0, 0);
        check("rst_abort.no_strobe_after", sq.size() - s0, 0);
    endtask

    // ---------------- main sequence ----------------
    vec_t tbl [7];

    initial begin
        rst = 1'b1; lineStart = 1'b0; writeBack = 1'b0;
        writeRowIndex = '0; readRowIndex = '0; writeRow = '0;
        for (int a = 0; a < 32768; a++) model_ram[a] = init_val(a);

        tbl[0] = '{wb:1, widx:5,   ridx:7,   pattern:0, extra_at:0,  scramble:0,
                   exp_writes:40, exp_waddr0:200,   exp_reads:40, exp_raddr0:280, exp_done:82};
        tbl[1] = '{wb:0, widx:0,   ridx:7,   pattern:1, extra_at:0,  scramble:0,
                   exp_writes:0,  exp_waddr0:0,     exp_reads:40, exp_raddr0:280, exp_done:42};
        tbl[2] = '{wb:1, widx:479, ridx:481, pattern:1, extra_at:0,  scramble:0,
                   exp_writes:40, exp_waddr0:19160, exp_reads:0,  exp_raddr0:19240, exp_done:82};
        tbl[3] = '{wb:1, widx:10,  ridx:5,   pattern:1, extra_at:10, scramble:0,
                   exp_writes:40, exp_waddr0:400,   exp_reads:40, exp_raddr0:200, exp_done:82};
        tbl[4] = '{wb:1, widx:20,  ridx:20,  pattern:1, extra_at:0,  scramble:1,
                   exp_writes:40, exp_waddr0:800,   exp_reads:40, exp_raddr0:800, exp_done:82};
        tbl[5] = '{wb:1, widx:480, ridx:3,   pattern:1, extra_at:0,  scramble:0,
                   exp_writes:0,  exp_waddr0:19200, exp_reads:40, exp_raddr0:120, exp_done:82};
        tbl[6] = '{wb:0, widx:100, ridx:511, pattern:1, extra_at:0,  scramble:0,
                   exp_writes:0,  exp_waddr0:4000,  exp_reads:0,  exp_raddr0:20440, exp_done:42};

        repeat (2) @(negedge clkDiv);
        check("reset.readRow_lo", int'(readRow[31:0]), 0);
        check_row("reset.readRow", readRow, '0);
        check("reset.reading", int'(reading), 0);
        check("reset.busy", int'(busy), 0);
        check("reset.overrun", int'(overrun), 0);
        check("reset.memWrite", int'(memWrite), 0);
        check("reset.memRead", int'(memRead), 0);
        check("reset.memAddr", int'(memAddr), 0);
        check("reset.memWriteData", int'(memWriteData), 0);
        #1 rst = 1'b0;
        repeat (2) @(negedge clkDiv);

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
            check($sformatf("vec%0d.overrun", i), int'(overrun), (i >= 3) ? 1 : 0);
            if (i == 1) begin
                check("vec1.readRow_word0", int'(readRow[15:0]), 16'h0700);
                check("vec1.readRow_word39", int'(readRow[639:624]), 16'h0727);
            end
        end

        reset_abort_test();
        run_txn(make_vec(1'b0, 0, 12, 1, 0, 1'b0), "post_rst_read");
        run_txn(make_vec(1'b1, 12, 12, 1, 0, 1'b0), "post_rst_full");

        for (int i = 0; i < 24; i++) begin
            bit wb;
            int widx, ridx, extra;
            wb    = 1'($urandom_range(0, 1));
            widx  = $urandom_range(0, 499);
            ridx  = ($urandom_range(0, 3) == 0) ? widx : $urandom_range(0, 499);
            extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, wb ? 82 : 42) : 0;
            run_txn(make_vec(wb, widx, ridx, 1, extra, 1'($urandom_range(0, 1))),
                    $sformatf("rand%0d", i));
            repeat ($urandom_range(0, 3)) @(negedge clkDiv);
        end

        check("global.write_and_read_overlap", both_hi, 0);
        check("global.idle_outputs_nonzero", idle_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
